// File: rtl/ants_pair_framer.sv
// Pairs a serial stream of resource elements into even/odd antenna buses with
// sop/eop framing, zero-pads short tails, repairs bad framing and counts packets/errors.
module ants_pair_framer #(
  parameter int ANT = 32,
  parameter int IW  = 32,
  parameter int CW  = 16
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_tvalid,
  input  logic                i_sop,
  input  logic                i_eop,
  input  logic [ANT*IW-1:0]   i_data,
  input  logic [63:0]         i_info_0,
  input  logic [63:0]         i_info_1,
  output logic                o_rvalid,
  output logic                o_sop,
  output logic                o_eop,
  output logic [ANT*IW-1:0]   o_ants_data_even,
  output logic [ANT*IW-1:0]   o_ants_data_odd,
  output logic                o_pad,
  output logic [63:0]         o_info_0,
  output logic [63:0]         o_info_1,
  output logic [CW-1:0]       o_pkt_cnt,
  output logic [CW-1:0]       o_err_cnt
);

  localparam int DW = ANT * IW;

  typedef enum logic [1:0] {IDLE, WAIT_ODD, WAIT_EVEN} state_t;

  typedef struct packed {
    logic [DW-1:0] even;
    logic [DW-1:0] odd;
    logic          sop;
    logic          eop;
    logic          pad;
    logic [63:0]   info_0;
    logic [63:0]   info_1;
  } pair_t;

  state_t        r_state, w_state_next;
  logic [DW-1:0] r_even;
  logic          r_first;
  logic [63:0]   r_sh_info_0, r_sh_info_1;

  // One-deep overflow slot: only a restart sop+eop beat yields two pairs at once
  logic          r_pend_v;
  pair_t         r_pend;

  logic          r_rvalid, r_sop, r_eop, r_pad;
  logic [DW-1:0] r_data_even, r_data_odd;
  logic [63:0]   r_info_0, r_info_1;
  logic [CW-1:0] r_pkt_cnt, r_err_cnt;

  pair_t         w_p, w_s, w_fresh, w_held, w_out;
  logic          w_p_v, w_s_v, w_out_v;
  logic          w_hold_load, w_sop_load, w_first_clr, w_err;

  // Pair templates: a lone sop RE, and the held even RE completed by this beat
  always_comb begin
    w_fresh        = '0;
    w_fresh.even   = i_data;
    w_fresh.sop    = 1'b1;
    w_fresh.eop    = 1'b1;
    w_fresh.pad    = 1'b1;
    w_fresh.info_0 = i_info_0;
    w_fresh.info_1 = i_info_1;

    w_held         = '0;
    w_held.even    = r_even;
    w_held.odd     = i_data;
    w_held.sop     = r_first;
    w_held.eop     = i_eop;
    w_held.info_0  = r_sh_info_0;
    w_held.info_1  = r_sh_info_1;
  end

  always_comb begin
    w_state_next = r_state;
    w_hold_load  = 1'b0;
    w_sop_load   = 1'b0;
    w_first_clr  = 1'b0;
    w_err        = 1'b0;
    w_p_v        = 1'b0;
    w_s_v        = 1'b0;
    w_p          = '0;
    w_s          = '0;

    if (i_tvalid) begin
      case (r_state)
        IDLE: begin
          if (i_sop) begin
            w_sop_load = 1'b1;
            if (i_eop) begin
              w_p_v = 1'b1;
              w_p   = w_fresh;
            end else begin
              w_state_next = WAIT_ODD;
            end
          end else begin
            w_err = 1'b1;
          end
        end

        WAIT_ODD: begin
          if (!i_sop) begin
            w_p_v        = 1'b1;
            w_p          = w_held;
            w_first_clr  = 1'b1;
            w_state_next = i_eop ? IDLE : WAIT_EVEN;
          end else begin
            w_p_v      = 1'b1;
            w_p        = w_held;
            w_p.odd    = '0;
            w_p.eop    = 1'b1;
            w_p.pad    = 1'b1;
            w_err      = 1'b1;
            w_sop_load = 1'b1;
            if (i_eop) begin
              w_s_v        = 1'b1;
              w_s          = w_fresh;
              w_state_next = IDLE;
            end else begin
              w_state_next = WAIT_ODD;
            end
          end
        end

        WAIT_EVEN: begin
          if (i_sop) begin
            w_err      = 1'b1;
            w_sop_load = 1'b1;
            if (i_eop) begin
              w_p_v        = 1'b1;
              w_p          = w_fresh;
              w_state_next = IDLE;
            end else begin
              w_state_next = WAIT_ODD;
            end
          end else begin
            w_hold_load = 1'b1;
            if (i_eop) begin
              w_p_v        = 1'b1;
              w_p          = w_held;
              w_p.even     = i_data;
              w_p.odd      = '0;
              w_p.eop      = 1'b1;
              w_p.pad      = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_state_next = WAIT_ODD;
            end
          end
        end

        default: w_state_next = IDLE;
      endcase
    end
  end

  // The pending pair is older than anything produced this cycle, so it goes first
  assign w_out_v = r_pend_v | w_p_v;
  assign w_out   = r_pend_v ? r_pend : w_p;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_even      <= '0;
      r_first     <= 1'b0;
      r_sh_info_0 <= '0;
      r_sh_info_1 <= '0;
      r_pend_v    <= 1'b0;
      r_pend      <= '0;
      r_rvalid    <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_pad       <= 1'b0;
      r_data_even <= '0;
      r_data_odd  <= '0;
      r_info_0    <= '0;
      r_info_1    <= '0;
      r_pkt_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_sop_load) begin
        r_even      <= i_data;
        r_sh_info_0 <= i_info_0;
        r_sh_info_1 <= i_info_1;
        r_first     <= 1'b1;
      end else begin
        if (w_hold_load) r_even  <= i_data;
        if (w_first_clr) r_first <= 1'b0;
      end

      if (r_pend_v) begin
        r_pend_v <= w_p_v;
        r_pend   <= w_p;
      end else begin
        r_pend_v <= w_s_v;
        r_pend   <= w_s;
      end

      r_rvalid <= w_out_v;
      r_sop    <= w_out_v & w_out.sop;
      r_eop    <= w_out_v & w_out.eop;
      r_pad    <= w_out_v & w_out.pad;
      if (w_out_v) begin
        r_data_even <= w_out.even;
        r_data_odd  <= w_out.odd;
      end
      if (w_out_v && w_out.sop) begin
        r_info_0 <= w_out.info_0;
        r_info_1 <= w_out.info_1;
      end

      if (w_out_v && w_out.eop) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      if (w_err && (r_err_cnt != {CW{1'b1}})) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign o_rvalid         = r_rvalid;
  assign o_sop            = r_sop;
  assign o_eop            = r_eop;
  assign o_pad            = r_pad;
  assign o_ants_data_even = r_data_even;
  assign o_ants_data_odd  = r_data_odd;
  assign o_info_0         = r_info_0;
  assign o_info_1         = r_info_1;
  assign o_pkt_cnt        = r_pkt_cnt;
  assign o_err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_ants_pair_framer.sv
// Scoreboard bench for ants_pair_framer: directed beats push expected pairs,
// a negedge monitor pops and compares every emitted pair including its latency.
module tb_ants_pair_framer;
  localparam int ANT = 2;
  localparam int IW  = 8;
  localparam int CW  = 4;
  localparam int DW  = ANT * IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tvalid = 1'b0, sop = 1'b0, eop = 1'b0;
  logic [DW-1:0] data = '0;
  logic [63:0]   info0 = '0, info1 = '0;

  logic          o_rvalid, o_sop, o_eop, o_pad;
  logic [DW-1:0] o_even, o_odd;
  logic [63:0]   o_info_0, o_info_1;
  logic [CW-1:0] o_pkt_cnt, o_err_cnt;

  ants_pair_framer #(.ANT(ANT), .IW(IW), .CW(CW)) dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_tvalid         (tvalid),
    .i_sop            (sop),
    .i_eop            (eop),
    .i_data           (data),
    .i_info_0         (info0),
    .i_info_1         (info1),
    .o_rvalid         (o_rvalid),
    .o_sop            (o_sop),
    .o_eop            (o_eop),
    .o_ants_data_even (o_even),
    .o_ants_data_odd  (o_odd),
    .o_pad            (o_pad),
    .o_info_0         (o_info_0),
    .o_info_1         (o_info_1),
    .o_pkt_cnt        (o_pkt_cnt),
    .o_err_cnt        (o_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] even;
    logic [DW-1:0] odd;
    logic          sop;
    logic          eop;
    logic          pad;
    logic [63:0]   i0;
    logic [63:0]   i1;
    int            due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pair(input logic [DW-1:0] ev, input logic [DW-1:0] od,
                             input logic s, input logic eo, input logic p,
                             input logic [63:0] i0, input logic [63:0] i1, input int due);
    exp_t x;
    x.even = ev; x.odd = od; x.sop = s; x.eop = eo; x.pad = p;
    x.i0 = i0; x.i1 = i1; x.due = due;
    q.push_back(x);
  endtask

  // Inputs change on the falling edge; the beat is captured on the next rising edge
  task automatic beat(input logic s, input logic eo, input logic [DW-1:0] d,
                      input logic [63:0] i0 = 64'hBAD0, input logic [63:0] i1 = 64'hBAD1);
    @(negedge clk);
    tvalid = 1'b1; sop = s; eop = eo; data = d; info0 = i0; info1 = i1;
  endtask

  // Idle cycles drive junk framing/headers that must be ignored while tvalid is low
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tvalid = 1'b0; sop = 1'b1; eop = 1'b1; data = 16'hDEAD;
      info0 = 64'hFEED; info1 = 64'hFEEE;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    tvalid = 1'b0; sop = 1'b0; eop = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_flags", {o_sop, o_eop, o_pad}, 0);
    chk("rst_even", o_even, 0);
    chk("rst_odd", o_odd, 0);
    chk("rst_info0", o_info_0, 0);
    chk("rst_info1", o_info_1, 0);
    chk("rst_pkt_cnt", o_pkt_cnt, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (o_rvalid) begin
      chk("pair_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        $display("[TB] pair even=%h odd=%h sop=%0d eop=%0d pad=%0d info0=%0h cycle=%0d",
                 o_even, o_odd, o_sop, o_eop, o_pad, o_info_0, cyc);
        chk("pair_even", o_even, e.even);
        chk("pair_odd", o_odd, e.odd);
        chk("pair_sop", o_sop, e.sop);
        chk("pair_eop", o_eop, e.eop);
        chk("pair_pad", o_pad, e.pad);
        chk("pair_latency", cyc, e.due);
        if (e.sop) begin
          chk("pair_info0", o_info_0, e.i0);
          chk("pair_info1", o_info_1, e.i1);
        end
      end
    end else begin
      chk("idle_flags", {o_sop, o_eop, o_pad}, 0);
    end
  end

  initial begin
    do_reset();

    // 4-RE packet, back to back
    beat(1, 0, 16'hA0A0, 64'h1111, 64'h2222);
    beat(0, 0, 16'hA1A1);
    expect_pair(16'hA0A0, 16'hA1A1, 1, 0, 0, 64'h1111, 64'h2222, cyc + 1);
    beat(0, 0, 16'hA2A2);
    beat(0, 1, 16'hA3A3);
    expect_pair(16'hA2A2, 16'hA3A3, 0, 1, 0, 0, 0, cyc + 1);
    idle(3);
    chk("s1_pkt_cnt", o_pkt_cnt, 1);
    chk("s1_err_cnt", o_err_cnt, 0);

    // 3-RE packet with gaps: padded tail
    beat(1, 0, 16'h0B01, 64'h5555, 64'h6666);
    idle(1);
    beat(0, 0, 16'h0B02);
    expect_pair(16'h0B01, 16'h0B02, 1, 0, 0, 64'h5555, 64'h6666, cyc + 1);
    idle(2);
    beat(0, 1, 16'h0B03);
    expect_pair(16'h0B03, 16'h0000, 0, 1, 1, 0, 0, cyc + 1);
    idle(3);
    chk("s2_pkt_cnt", o_pkt_cnt, 2);

    // Single-beat packet
    beat(1, 1, 16'h0C01, 64'h1234, 64'h5678);
    expect_pair(16'h0C01, 16'h0000, 1, 1, 1, 64'h1234, 64'h5678, cyc + 1);
    idle(3);
    chk("s3_pkt_cnt", o_pkt_cnt, 3);
    chk("s3_info0_hold", o_info_0, 64'h1234);
    chk("s3_err_cnt", o_err_cnt, 0);

    // sop while an even RE is held
    beat(1, 0, 16'h0D01, 64'hAAAA, 64'hAAAB);
    beat(1, 0, 16'h0D02, 64'hBBBB, 64'hBBBC);
    expect_pair(16'h0D01, 16'h0000, 1, 1, 1, 64'hAAAA, 64'hAAAB, cyc + 1);
    beat(0, 1, 16'h0D03);
    expect_pair(16'h0D02, 16'h0D03, 1, 1, 0, 64'hBBBB, 64'hBBBC, cyc + 1);
    idle(3);
    chk("s4_err_cnt", o_err_cnt, 1);
    chk("s4_pkt_cnt", o_pkt_cnt, 5);

    // Restart with sop+eop yields two pairs; a following sop+eop queues behind
    beat(1, 0, 16'h0E01, 64'hCCC1, 64'hCCC2);
    beat(1, 1, 16'h0E02, 64'hDDD1, 64'hDDD2);
    expect_pair(16'h0E01, 16'h0000, 1, 1, 1, 64'hCCC1, 64'hCCC2, cyc + 1);
    expect_pair(16'h0E02, 16'h0000, 1, 1, 1, 64'hDDD1, 64'hDDD2, cyc + 2);
    beat(1, 1, 16'h0E03, 64'hEEE1, 64'hEEE2);
    expect_pair(16'h0E03, 16'h0000, 1, 1, 1, 64'hEEE1, 64'hEEE2, cyc + 2);
    idle(4);
    chk("s4b_err_cnt", o_err_cnt, 2);
    chk("s4b_pkt_cnt", o_pkt_cnt, 8);

    // sop with no RE held truncates the open packet
    beat(1, 0, 16'h0F01, 64'hF1, 64'hF2);
    beat(0, 0, 16'h0F02);
    expect_pair(16'h0F01, 16'h0F02, 1, 0, 0, 64'hF1, 64'hF2, cyc + 1);
    beat(1, 0, 16'h0F03, 64'h71, 64'h72);
    beat(0, 1, 16'h0F04);
    expect_pair(16'h0F03, 16'h0F04, 1, 1, 0, 64'h71, 64'h72, cyc + 1);
    idle(3);
    chk("s4c_err_cnt", o_err_cnt, 3);
    chk("s4c_pkt_cnt", o_pkt_cnt, 9);

    // Stray beats after reset, then error counter saturation
    do_reset();
    repeat (5) beat(0, 0, 16'h1111);
    idle(2);
    chk("s5_err_cnt5", o_err_cnt, 5);
    repeat (10) beat(0, 1, 16'h2222);
    idle(2);
    chk("s5_err_sat", o_err_cnt, 15);
    beat(0, 0, 16'h3333);
    idle(2);
    chk("s5_err_stay", o_err_cnt, 15);
    chk("s5_pkt_cnt", o_pkt_cnt, 0);

    // Reset while an even RE is held
    beat(1, 0, 16'h2001, 64'h1, 64'h2);
    beat(0, 0, 16'h2002);
    expect_pair(16'h2001, 16'h2002, 1, 0, 0, 64'h1, 64'h2, cyc + 1);
    idle(2);
    beat(0, 0, 16'h2003);
    do_reset();
    beat(1, 0, 16'h3001, 64'h3, 64'h4);
    beat(0, 1, 16'h3002);
    expect_pair(16'h3001, 16'h3002, 1, 1, 0, 64'h3, 64'h4, cyc + 1);
    idle(3);
    chk("s7_pkt_cnt", o_pkt_cnt, 1);
    chk("s7_err_cnt", o_err_cnt, 0);

    idle(2);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
